// File: rtl/fire_pkg.sv
// ============================================================================
// Module      : fire_pkg
// Description : Shared types and constants for the fire pulser block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fire_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int c_DEAD_PRESCALE = 4;
    localparam int c_CNT_W         = 16;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [c_CNT_W-1:0] sat_inc(input logic [c_CNT_W-1:0] v);
        return (v == {c_CNT_W{1'b1}}) ? v : v + c_CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trig_sync.sv
// ============================================================================
// Module      : trig_sync
// Description : Two-flop synchronizer plus registered rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_sync #(
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] trig_in,
    output logic [NCH-1:0] edge_det
);

    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_prev;
    logic [NCH-1:0] r_edge;

    // Ones at reset: an input already high when reset lifts is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
            r_edge  <= '0;
        end else begin
            r_sync1 <= trig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    assign edge_det = r_edge;

endmodule

`default_nettype wire

// File: rtl/fire_pulser.sv
// ============================================================================
// Module      : fire_pulser
// Description : Trigger-to-fire pulser with programmable width and dead time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fire_pulser
    import fire_pkg::*;
#(
    parameter int NCH           = 8,
    parameter int DEAD_PRESCALE = c_DEAD_PRESCALE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     trig_in,
    input  logic               enable,
    input  logic [7:0]         firingticks,
    input  logic [7:0]         deadticks,
    input  logic               clr_counts,
    output logic [NCH-1:0]     fire_out,
    output logic               busy,
    output logic [c_CNT_W-1:0] fire_count,
    output logic [c_CNT_W-1:0] missed_count
);

    // Tick counter must hold both a fire width (8 bits) and 255*prescale.
    localparam int c_DEAD_MAX = 255 * DEAD_PRESCALE;
    localparam int c_TW       = ($clog2(c_DEAD_MAX + 1) > 8) ? $clog2(c_DEAD_MAX + 1) : 8;
    localparam logic [c_TW-1:0] c_PRESCALE = c_TW'(DEAD_PRESCALE);

    logic [NCH-1:0]     w_edge;
    logic               w_any_edge;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_TW-1:0]    r_tick;
    logic [c_TW-1:0]    w_tick_nxt;
    logic [7:0]         r_dead_lat;
    logic [7:0]         w_dead_nxt;
    logic [NCH-1:0]     r_pattern;
    logic [NCH-1:0]     w_pattern_nxt;
    logic               w_accept;
    logic               w_miss;

    logic [NCH-1:0]     r_fire_out;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_fire_count;
    logic [c_CNT_W-1:0] r_missed_count;

    trig_sync #(
        .NCH (NCH)
    ) u_trig_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_in  (trig_in),
        .edge_det (w_edge)
    );

    assign w_any_edge = |w_edge;

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_dead_nxt    = r_dead_lat;
        w_pattern_nxt = r_pattern;
        w_accept      = 1'b0;
        w_miss        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_any_edge) begin
                    if (enable) begin
                        w_accept      = 1'b1;
                        w_state_nxt   = ST_FIRE;
                        w_pattern_nxt = w_edge;
                        w_dead_nxt    = deadticks;
                        // A zero width still yields a single-cycle pulse.
                        w_tick_nxt    = (firingticks == 8'd0) ? '0
                                                              : c_TW'(firingticks - 8'd1);
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                w_miss = w_any_edge;
                if (r_tick == '0) begin
                    if (r_dead_lat != 8'd0) begin
                        w_state_nxt = ST_DEAD;
                        w_tick_nxt  = c_TW'(r_dead_lat) * c_PRESCALE - c_TW'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_tick_nxt = r_tick - c_TW'(1);
                end
            end
            ST_DEAD: begin
                w_miss = w_any_edge;
                if (r_tick == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tick_nxt = r_tick - c_TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_tick         <= '0;
            r_dead_lat     <= '0;
            r_pattern      <= '0;
            r_fire_out     <= '0;
            r_busy         <= 1'b0;
            r_fire_count   <= '0;
            r_missed_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_dead_lat <= w_dead_nxt;
            r_pattern  <= w_pattern_nxt;
            r_fire_out <= (w_state_nxt == ST_FIRE) ? w_pattern_nxt : '0;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (clr_counts) begin
                r_fire_count   <= '0;
                r_missed_count <= '0;
            end else begin
                if (w_accept) begin
                    r_fire_count <= sat_inc(r_fire_count);
                end
                if (w_miss) begin
                    r_missed_count <= sat_inc(r_missed_count);
                end
            end
        end
    end

    assign fire_out     = r_fire_out;
    assign busy         = r_busy;
    assign fire_count   = r_fire_count;
    assign missed_count = r_missed_count;

endmodule

`default_nettype wire

// File: tb/tb_fire_pulser.sv
// ============================================================================
// Module      : tb_fire_pulser
// Description : Directed bench with a duration-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fire_pulser;

    localparam int NCH = 8;
    localparam int PRE = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] trig_in;
    logic           enable;
    logic [7:0]     firingticks;
    logic [7:0]     deadticks;
    logic           clr_counts;
    logic [NCH-1:0] fire_out;
    logic           busy;
    logic [15:0]    fire_count;
    logic [15:0]    missed_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: input history and remaining fire/dead cycles.
    logic [NCH-1:0] m_hist [4];
    int             m_fire_left = 0;
    int             m_dead_left = 0;
    logic [NCH-1:0] m_pat  = '0;
    logic [15:0]    m_fc   = '0;
    logic [15:0]    m_mc   = '0;
    logic [NCH-1:0] m_fire = '0;
    logic           m_busy = 1'b0;
    logic           preload_req;

    fire_pulser #(
        .NCH           (NCH),
        .DEAD_PRESCALE (PRE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig_in      (trig_in),
        .enable       (enable),
        .firingticks  (firingticks),
        .deadticks    (deadticks),
        .clr_counts   (clr_counts),
        .fire_out     (fire_out),
        .busy         (busy),
        .fire_count   (fire_count),
        .missed_count (missed_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // An edge reaches the pulser three samples after trig_in is first seen high.
    task automatic model_step();
        logic [NCH-1:0] e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_hist[i] = '1;
            m_fire_left = 0;
            m_dead_left = 0;
            m_pat       = '0;
            m_fc        = '0;
            m_mc        = '0;
        end else begin
            e = m_hist[2] & ~m_hist[3];
            if (preload_req) m_fc = 16'hFFFE;
            if (m_fire_left == 0 && m_dead_left == 0 && enable && e != '0) begin
                m_fire_left = (firingticks == 8'd0) ? 1 : int'(firingticks);
                m_dead_left = int'(deadticks) * PRE;
                m_pat       = e;
                if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            end else begin
                if (e != '0 && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
                if (m_fire_left > 0) m_fire_left--;
                else if (m_dead_left > 0) m_dead_left--;
            end
            if (clr_counts) begin
                m_fc = '0;
                m_mc = '0;
            end
            m_hist[3] = m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = trig_in;
        end
        m_fire = (m_fire_left > 0) ? m_pat : '0;
        m_busy = (m_fire_left > 0) || (m_dead_left > 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("model fire_out", 32'(fire_out), 32'(m_fire));
            chk("model busy", 32'(busy), 32'(m_busy));
            chk("model fire_count", 32'(fire_count), 32'(m_fc));
            chk("model missed_count", 32'(missed_count), 32'(m_mc));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NCH-1:0] mask);
        @(negedge clk) trig_in = mask;
        @(negedge clk) trig_in = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, need 0", busy, n);
        end
    endtask

    task automatic measure(output int nf, output int nb);
        nf = 0;
        nb = 0;
        while (busy === 1'b1 && nb < 3000) begin
            if (fire_out != '0) nf++;
            nb++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nf;
        int nb;
        rst_n       = 1'b0;
        trig_in     = '0;
        enable      = 1'b1;
        firingticks = 8'd9;
        deadticks   = 8'd10;
        clr_counts  = 1'b0;
        preload_req = 1'b0;
        @(negedge clk);
        chk("reset fire_out", 32'(fire_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset fire_count", 32'(fire_count), 32'h0);
        chk("reset missed_count", 32'(missed_count), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Basic pulse: width 9, dead 10*4.
        pulse(8'h04);
        tick(2);
        chk("latency k+2 quiet", 32'(fire_out), 32'h0);
        tick(1);
        chk("latency k+3 fire", 32'(fire_out), 32'h04);
        measure(nf, nb);
        chk("fire width 9", 32'(nf), 32'd9);
        chk("busy span 49", 32'(nb), 32'd49);
        chk("fire_count one", 32'(fire_count), 32'd1);
        chk("missed none", 32'(missed_count), 32'd0);
        tick(2);

        // Edge during dead time is missed; after idle it fires.
        pulse(8'h04);
        tick(18);
        pulse(8'h20);
        wait_idle();
        chk("missed during dead", 32'(missed_count), 32'd1);
        chk("fire_count two", 32'(fire_count), 32'd2);
        pulse(8'h20);
        tick(2);
        chk("ch5 quiet k+2", 32'(fire_out), 32'h0);
        tick(1);
        chk("ch5 fires", 32'(fire_out), 32'h20);
        wait_idle();
        chk("fire_count three", 32'(fire_count), 32'd3);

        // Zero width / zero dead: back-to-back edges both fire.
        @(negedge clk);
        firingticks = 8'd0;
        deadticks   = 8'd0;
        tick(2);
        @(negedge clk) trig_in = 8'h02;
        @(negedge clk) trig_in = 8'h00;
        @(negedge clk) trig_in = 8'h02;
        @(negedge clk) trig_in = 8'h00;
        chk("zw quiet", 32'(fire_out), 32'h0);
        @(negedge clk);
        chk("zw first pulse", 32'(fire_out), 32'h02);
        @(negedge clk);
        chk("zw gap", 32'(fire_out), 32'h0);
        @(negedge clk);
        chk("zw second pulse", 32'(fire_out), 32'h02);
        @(negedge clk);
        chk("zw done", 32'(busy), 32'h0);
        chk("fire_count five", 32'(fire_count), 32'd5);

        // Two channels together; width and enable changes mid-pulse ignored.
        firingticks = 8'd5;
        deadticks   = 8'd1;
        pulse(8'h81);
        tick(3);
        chk("dual channel", 32'(fire_out), 32'h81);
        @(negedge clk);
        firingticks = 8'd1;
        enable      = 1'b0;
        measure(nf, nb);
        chk("width held", 32'(nf), 32'd4);
        chk("dead held", 32'(nb), 32'd8);
        chk("fire_count six", 32'(fire_count), 32'd6);

        // Disabled idle rejects the edge.
        pulse(8'h08);
        tick(5);
        chk("disabled no fire", 32'(fire_out), 32'h0);
        chk("missed disabled", 32'(missed_count), 32'd2);
        enable = 1'b1;

        // Reset during dead time; input held high across release.
        firingticks = 8'd9;
        deadticks   = 8'd10;
        pulse(8'h01);
        tick(14);
        chk("in dead busy", 32'(busy), 32'h1);
        rst_n   = 1'b0;
        trig_in = 8'h08;
        @(negedge clk);
        chk("mid reset busy", 32'(busy), 32'h0);
        chk("mid reset fire_count", 32'(fire_count), 32'h0);
        chk("mid reset missed", 32'(missed_count), 32'h0);
        rst_n = 1'b1;
        tick(10);
        chk("held high no fire", 32'(fire_count), 32'h0);
        chk("held high idle", 32'(busy), 32'h0);
        trig_in = '0;
        tick(4);

        // Saturation via preload, then clear racing an accepted trigger.
        firingticks = 8'd0;
        deadticks   = 8'd0;
        @(negedge clk);
        force dut.r_fire_count = 16'hFFFE;
        preload_req = 1'b1;
        #1 release dut.r_fire_count;
        @(negedge clk);
        preload_req = 1'b0;
        pulse(8'h02);
        tick(5);
        chk("reach saturation", 32'(fire_count), 32'hFFFF);
        pulse(8'h02);
        tick(5);
        chk("stay saturated", 32'(fire_count), 32'hFFFF);
        @(negedge clk) trig_in = 8'h10;
        @(negedge clk) trig_in = 8'h00;
        @(negedge clk);
        @(negedge clk) clr_counts = 1'b1;
        @(negedge clk) clr_counts = 1'b0;
        chk("fire with clear", 32'(fire_out), 32'h10);
        chk("clear wins", 32'(fire_count), 32'h0);
        tick(3);
        chk("clear holds", 32'(fire_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
